// File: rtl/mvm_rf_load_sequencer.sv
// Weight-word to single-beat AXIS packet sequencer for MVM register files.
// Optional perf counters when RF_LOAD_PERF_EN is defined.
module mvm_rf_load_sequencer #(
  parameter int DATAW  = 512,
  parameter int ADDRW  = 9,
  parameter int NUM_RF = 64,
  parameter int USERW  = 75,
  parameter int DESTW  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [6:0]       cfg_num_rf,
  input  logic [ADDRW:0]   cfg_num_addr,
  input  logic [ADDRW-1:0] cfg_base_addr,
  input  logic [DESTW-1:0] cfg_dest,
  input  logic             wt_valid,
  output logic             wt_ready,
  input  logic [DATAW-1:0] wt_data,
  output logic             axis_m_tvalid,
  input  logic             axis_m_tready,
  output logic [DATAW-1:0] axis_m_tdata,
  output logic [USERW-1:0] axis_m_tuser,
  output logic [DESTW-1:0] axis_m_tdest,
  output logic             axis_m_tlast,
  output logic             busy,
  output logic             done,
`ifdef RF_LOAD_PERF_EN
  output logic             cfg_err,
  output logic [31:0]      perf_beats,
  output logic [31:0]      perf_stall
`else
  output logic             cfg_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [6:0]        num_rf_q;
  logic [6:0]        rf_idx;
  logic [ADDRW:0]    num_addr_q;
  logic [ADDRW:0]    addr_idx;
  logic [ADDRW-1:0]  base_q;
  logic [DESTW-1:0]  dest_q;
  logic              aborted;

  logic              cfg_ok;
  logic              start_ok;
  logic              start_bad;
  logic              accept;
  logic              rf_last;
  logic              last_word;
  logic              hs;
  logic [ADDRW-1:0]  addr_cur;
  logic [NUM_RF-1:0] rf_sel;

  assign cfg_ok = (cfg_num_rf != 7'd0)
               && ({25'd0, cfg_num_rf} <= 32'(NUM_RF))
               && (cfg_num_addr != '0)
               && ({{(31-ADDRW){1'b0}}, cfg_num_addr}
                   <= 32'(2**ADDRW));

  assign start_ok  = (state == IDLE) && cfg_start && cfg_ok;
  assign start_bad = (state == IDLE) && cfg_start && !cfg_ok;

  assign wt_ready = (state == LOAD)
                 && (!axis_m_tvalid || axis_m_tready);
  assign accept   = wt_valid && wt_ready;
  assign hs       = axis_m_tvalid && axis_m_tready;

  assign rf_last   = (rf_idx == num_rf_q - 7'd1);
  assign last_word = rf_last
                  && (addr_idx == num_addr_q - (ADDRW+1)'(1));

  assign addr_cur = base_q + addr_idx[ADDRW-1:0];
  assign rf_sel   = {{(NUM_RF-1){1'b0}}, 1'b1} << rf_idx;

  assign busy         = (state != IDLE);
  assign axis_m_tlast = axis_m_tvalid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = LOAD;
      LOAD:    if ((accept && last_word) || cfg_abort)
                 state_nx = DRAIN;
      DRAIN:   if (!axis_m_tvalid || axis_m_tready)
                 state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_rf_q      <= '0;
      num_addr_q    <= '0;
      base_q        <= '0;
      dest_q        <= '0;
      rf_idx        <= '0;
      addr_idx      <= '0;
      aborted       <= 1'b0;
      axis_m_tvalid <= 1'b0;
      axis_m_tdata  <= '0;
      axis_m_tuser  <= '0;
      axis_m_tdest  <= '0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      done    <= (state == DRAIN) && hs && !aborted;
      cfg_err <= start_bad;
      if (start_ok) begin
        num_rf_q   <= cfg_num_rf;
        num_addr_q <= cfg_num_addr;
        base_q     <= cfg_base_addr;
        dest_q     <= cfg_dest;
        rf_idx     <= '0;
        addr_idx   <= '0;
        aborted    <= 1'b0;
      end
      // an abort racing the final word still completes the load
      if ((state == LOAD) && cfg_abort && !(accept && last_word))
        aborted <= 1'b1;
      if (accept) begin
        if (rf_last) begin
          rf_idx   <= '0;
          addr_idx <= addr_idx + (ADDRW+1)'(1);
        end else begin
          rf_idx   <= rf_idx + 7'd1;
        end
        axis_m_tvalid <= 1'b1;
        axis_m_tdata  <= wt_data;
        axis_m_tuser  <= {rf_sel, 2'b11, addr_cur};
        axis_m_tdest  <= dest_q;
      end else if (axis_m_tready) begin
        axis_m_tvalid <= 1'b0;
      end
    end
  end

`ifdef RF_LOAD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (hs && (perf_beats != '1))
        perf_beats <= perf_beats + 32'd1;
      if (axis_m_tvalid && !axis_m_tready && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
